// File: rtl/sumador_restador_serie.sv
// sumador_restador_serie
//   Digit-serial two's-complement add/subtract unit. A request in IDLE
//   latches both operands, then DIGIT bits are added per clock, LSB digit
//   first, until the full WIDTH-bit result is assembled. The result and
//   flags are held until the next operation completes.
//
//   Optional feature macro: SUMRES_SATURACION_EN
//     defined     -> on signed overflow, resultado clamps to the largest
//                    magnitude of entA's sign (0111..1 or 1000..0)
//     not defined -> plain modulo 2^WIDTH result
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset, discards any operation
//   sumar      in   add request (sampled in IDLE only)
//   restar     in   subtract request (sampled in IDLE only, wins over sumar)
//   entA       in   operand A, latched on acceptance
//   entM       in   operand M, latched on acceptance
//   ocupado    out  high while an operation is computing or finishing
//   listo      out  one-cycle pulse: resultado/acarreo/desborde valid
//   resultado  out  sum or difference
//   acarreo    out  carry out of the MSB (subtract: 1 = no borrow)
//   desborde   out  signed overflow
module sumador_restador_serie #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sumar,
  input  logic             restar,
  input  logic [WIDTH-1:0] entA,
  input  logic [WIDTH-1:0] entM,
  output logic             ocupado,
  output logic             listo,
  output logic [WIDTH-1:0] resultado,
  output logic             acarreo,
  output logic             desborde
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("sumador_restador_serie: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             ocupado_reg;
  logic             listo_reg;
  logic [WIDTH-1:0] resultado_reg;
  logic             acarreo_reg;
  logic             desborde_reg;
`ifdef SUMRES_SATURACION_EN
  logic             sign_a_reg;   // A shifts away during CALC; keep its sign for the clamp
`endif

  // Ripple-carry adder for one digit. c_chain[DIGIT-1] is the carry into
  // the digit's top bit, which in the last digit is the carry into the MSB.
  logic [DIGIT:0]   c_chain;
  logic [DIGIT-1:0] s_digit;

  assign c_chain[0] = carry_reg;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_ripple
      assign s_digit[gi]   = a_reg[gi] ^ b_reg[gi] ^ c_chain[gi];
      assign c_chain[gi+1] = (a_reg[gi] & b_reg[gi]) | (c_chain[gi] & (a_reg[gi] ^ b_reg[gi]));
    end
  endgenerate

  // Sum digits enter at the top of the accumulator, so after NDIG shifts
  // the first (least significant) digit has landed at bit 0.
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;

  generate
    if (DIGIT == WIDTH) begin : g_single_digit
      assign acc_next = s_digit;
      assign a_next   = '0;
      assign b_next   = '0;
    end else begin : g_multi_digit
      assign acc_next = {s_digit, acc_reg[WIDTH-1:DIGIT]};
      assign a_next   = {{DIGIT{1'b0}}, a_reg[WIDTH-1:DIGIT]};
      assign b_next   = {{DIGIT{1'b0}}, b_reg[WIDTH-1:DIGIT]};
    end
  endgenerate

  logic             ovf_next;
  logic [WIDTH-1:0] res_final;

  assign ovf_next = c_chain[DIGIT] ^ c_chain[DIGIT-1];

`ifdef SUMRES_SATURACION_EN
  assign res_final = !ovf_next  ? acc_next :
                     sign_a_reg ? {1'b1, {(WIDTH-1){1'b0}}} :
                                  {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign res_final = acc_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      carry_reg     <= 1'b0;
      ocupado_reg   <= 1'b0;
      listo_reg     <= 1'b0;
      resultado_reg <= '0;
      acarreo_reg   <= 1'b0;
      desborde_reg  <= 1'b0;
`ifdef SUMRES_SATURACION_EN
      sign_a_reg    <= 1'b0;
`endif
    end else begin
      listo_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sumar || restar) begin
            // Subtraction is A + ~M + 1: invert M here, inject the +1 as carry-in.
            a_reg       <= entA;
            b_reg       <= restar ? ~entM : entM;
            carry_reg   <= restar;
            cnt_reg     <= '0;
            ocupado_reg <= 1'b1;
            state_reg   <= CALC;
`ifdef SUMRES_SATURACION_EN
            sign_a_reg  <= entA[WIDTH-1];
`endif
          end
        end
        CALC: begin
          a_reg     <= a_next;
          b_reg     <= b_next;
          acc_reg   <= acc_next;
          carry_reg <= c_chain[DIGIT];
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            resultado_reg <= res_final;
            acarreo_reg   <= c_chain[DIGIT];
            desborde_reg  <= ovf_next;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          ocupado_reg <= 1'b0;
          listo_reg   <= 1'b1;
          state_reg   <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ocupado   = ocupado_reg;
  assign listo     = listo_reg;
  assign resultado = resultado_reg;
  assign acarreo   = acarreo_reg;
  assign desborde  = desborde_reg;

endmodule

// File: tb/tb_sumador_restador_serie.sv
// Testbench for sumador_restador_serie (WIDTH=8, DIGIT=2).
// A transaction-level reference model predicts every output on every
// cycle; directed operations additionally pin hand-computed literals.
module tb_sumador_restador_serie;

  localparam int W    = 8;
  localparam int D    = 2;
  localparam int NDIG = W / D;

`ifdef SUMRES_SATURACION_EN
  localparam logic [7:0] E_OVF_ADD = 8'h7F;
  localparam logic [7:0] E_OVF_SUB = 8'h80;
`else
  localparam logic [7:0] E_OVF_ADD = 8'h80;
  localparam logic [7:0] E_OVF_SUB = 8'h7F;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         sumar;
  logic         restar;
  logic [W-1:0] entA;
  logic [W-1:0] entM;
  logic         ocupado;
  logic         listo;
  logic [W-1:0] resultado;
  logic         acarreo;
  logic         desborde;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  sumador_restador_serie #(.WIDTH(W), .DIGIT(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .sumar     (sumar),
    .restar    (restar),
    .entA      (entA),
    .entM      (entM),
    .ocupado   (ocupado),
    .listo     (listo),
    .resultado (resultado),
    .acarreo   (acarreo),
    .desborde  (desborde)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic from signed/unsigned integer rules: {v, c, result}
  function automatic logic [9:0] ref_op(input logic sub, input logic [7:0] a, input logic [7:0] m);
    int sa;
    int sm;
    int exact;
    logic c;
    logic v;
    logic [7:0] r;
    sa    = int'($signed(a));
    sm    = int'($signed(m));
    exact = sub ? sa - sm : sa + sm;
    v     = (exact > 127) || (exact < -128);
    c     = sub ? (a >= m) : ((int'(a) + int'(m)) > 255);
    r     = 8'(exact);
`ifdef SUMRES_SATURACION_EN
    if (v) r = (sa < 0) ? 8'h80 : 8'h7F;
`endif
    return {v, c, r};
  endfunction

  // Cycle-level timing model: accept, NDIG compute cycles, results visible
  // after the last compute edge, listo one cycle later.
  int         m_phase = 0;
  logic       m_busy  = 1'b0;
  logic       m_listo = 1'b0;
  logic [7:0] m_res   = '0;
  logic       m_c     = 1'b0;
  logic       m_v     = 1'b0;
  logic [9:0] m_pend  = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0;
      m_busy  <= 1'b0;
      m_listo <= 1'b0;
      m_res   <= '0;
      m_c     <= 1'b0;
      m_v     <= 1'b0;
    end else begin
      m_listo <= 1'b0;
      if (m_phase == 0) begin
        if (sumar || restar) begin
          m_pend  <= ref_op(restar, entA, entM);
          m_phase <= 1;
          m_busy  <= 1'b1;
        end
      end else if (m_phase == NDIG) begin
        {m_v, m_c, m_res} <= m_pend;
        m_phase <= m_phase + 1;
      end else if (m_phase == NDIG + 1) begin
        m_phase <= 0;
        m_busy  <= 1'b0;
        m_listo <= 1'b1;
      end else begin
        m_phase <= m_phase + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ocupado",   32'(ocupado),   32'(m_busy));
      chk("listo",     32'(listo),     32'(m_listo));
      chk("resultado", 32'(resultado), 32'(m_res));
      chk("acarreo",   32'(acarreo),   32'(m_c));
      chk("desborde",  32'(desborde),  32'(m_v));
    end
  end

  // Issue one request from IDLE, wait for listo, compare against literals.
  task automatic run_lit(input string name, input logic s, input logic r,
                         input logic [7:0] a, input logic [7:0] m,
                         input logic [7:0] exp_r, input logic exp_c, input logic exp_v);
    int lat;
    int occ;
    bit got;
    @(posedge clk); #1;
    sumar = s; restar = r; entA = a; entM = m;
    @(posedge clk); #1;
    sumar = 1'b0; restar = 1'b0; entA = ~a; entM = ~m;
    occ = ocupado ? 1 : 0;
    lat = 0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      lat++;
      if (listo) got = 1'b1;
      else if (ocupado) occ++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no listo expected listo within 20 cycles", name);
    end else begin
      chk({name, "_latency"}, 32'(lat), 32'(NDIG + 1));
      chk({name, "_ocupado_cycles"}, 32'(occ), 32'(NDIG + 1));
      chk({name, "_res"}, 32'(resultado), 32'(exp_r));
      chk({name, "_carry"}, 32'(acarreo), 32'(exp_c));
      chk({name, "_ovf"}, 32'(desborde), 32'(exp_v));
    end
    $display("op %s: A=%02h M=%02h sub=%0b -> res=%02h c=%0b v=%0b lat=%0d",
             name, a, m, r, resultado, acarreo, desborde, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 1ms");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int listo_cnt;
    logic [7:0] pick [5];
    pick[0] = 8'h00; pick[1] = 8'h01; pick[2] = 8'h7F; pick[3] = 8'h80; pick[4] = 8'hFF;

    reset = 1'b1; sumar = 1'b0; restar = 1'b0; entA = '0; entM = '0;
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    chk("reset_ocupado", 32'(ocupado), 32'd0);
    chk("reset_listo", 32'(listo), 32'd0);
    chk("reset_res", 32'(resultado), 32'd0);
    reset = 1'b0;

    run_lit("add_100_27", 1'b1, 1'b0, 8'd100, 8'd27, 8'h7F, 1'b0, 1'b0);
    run_lit("add_100_28", 1'b1, 1'b0, 8'd100, 8'd28, E_OVF_ADD, 1'b0, 1'b1);
    run_lit("sub_5_7", 1'b0, 1'b1, 8'd5, 8'd7, 8'hFE, 1'b0, 1'b0);
    run_lit("sub_80_01", 1'b0, 1'b1, 8'h80, 8'h01, E_OVF_SUB, 1'b1, 1'b1);
    run_lit("both_9_4", 1'b1, 1'b1, 8'd9, 8'd4, 8'h05, 1'b1, 1'b0);
    run_lit("sub_zero", 1'b0, 1'b1, 8'h37, 8'h00, 8'h37, 1'b1, 1'b0);
    run_lit("add_neg", 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0);

    // New request during CALC must be ignored: exactly one listo, first result kept.
    @(posedge clk); #1;
    sumar = 1'b1; entA = 8'd100; entM = 8'd27;
    @(posedge clk); #1;
    sumar = 1'b0;
    @(posedge clk); #1;
    sumar = 1'b1; restar = 1'b1; entA = 8'h11; entM = 8'h22;
    @(posedge clk); #1;
    sumar = 1'b0; restar = 1'b0;
    listo_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (listo) listo_cnt++;
    end
    chk("ignore_listo_count", 32'(listo_cnt), 32'd1);
    chk("ignore_res", 32'(resultado), 32'h7F);
    $display("op ignore_mid_calc: listo_count=%0d res=%02h", listo_cnt, resultado);

    // Reset during the second CALC cycle discards the operation.
    @(posedge clk); #1;
    restar = 1'b1; entA = 8'd5; entM = 8'd7;
    @(posedge clk); #1;
    restar = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_ocupado", 32'(ocupado), 32'd0);
    chk("midreset_res", 32'(resultado), 32'd0);
    chk("midreset_listo", 32'(listo), 32'd0);
    listo_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (listo) listo_cnt++;
    end
    chk("midreset_no_listo", 32'(listo_cnt), 32'd0);
    $display("op mid_reset: ocupado=%0b res=%02h listo_count=%0d", ocupado, resultado, listo_cnt);
    run_lit("after_reset", 1'b1, 1'b0, 8'd100, 8'd27, 8'h7F, 1'b0, 1'b0);

    // Randomised traffic with boundary operands, back-to-back and ignored
    // requests, and occasional resets; the per-cycle model checks it all.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      reset  = ($urandom_range(0, 59) == 0);
      sumar  = ($urandom_range(0, 2) != 0);
      restar = ($urandom_range(0, 1) != 0);
      entA   = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 4)] : 8'($urandom);
      entM   = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 4)] : 8'($urandom);
    end
    @(posedge clk); #1;
    reset = 1'b0; sumar = 1'b0; restar = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
